// File: rtl/instr_prefetch_pkg.sv
// rtl/instr_prefetch_pkg.sv - shared constants and types for the instruction prefetch queue
package instr_prefetch_pkg;

  localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// rtl/instr_prefetch_if.sv - redirect, instruction-memory and core-side signals of the prefetch queue
interface instr_prefetch_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/instr_prefetch_fifo.sv
// rtl/instr_prefetch_fifo.sv - in-order {pc, instr} storage with flush; DEPTH must be a power of two
module prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - sequential instruction prefetch queue with redirect flush
// Optional same-cycle response bypass when empty: PREFETCH_BYPASS_EN.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = RISCV_NOP
) (
  input  logic               clk,
  input  logic               res,
  instr_prefetch_if.master   bus
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   rpc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW:0]   inflight;
  logic          rsp_valid;
  logic          keep;
  logic          grant;
  logic          fifo_empty;
  logic          bypass;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  // Outstanding requests reserve a slot each, so the queue cannot overflow.
  assign inflight   = {1'b0, count} + {1'b0, outstanding};
  assign rsp_valid  = bus.imem_rvalid && (outstanding != '0);
  assign keep       = rsp_valid && (drop == '0);
  assign fifo_empty = (count == '0);

  assign bus.imem_req  = !res && !bus.redirect && (inflight < DEPTH_W);
  assign bus.imem_addr = fpc;
  assign grant         = bus.imem_req && bus.imem_gnt;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = keep && fifo_empty && !bus.redirect;
  assign push   = keep && !bus.redirect && !(fifo_empty && bus.inst_ready);
`else
  assign bypass = 1'b0;
  assign push   = keep && !bus.redirect;
`endif

  assign pop       = !fifo_empty && bus.inst_ready && !bus.redirect;
  assign push_data = '{pc: rpc, instr: bus.imem_rdata};

  assign bus.inst_valid = !fifo_empty || bypass;
  assign bus.inst_data  = !fifo_empty ? head.instr : (bypass ? bus.imem_rdata : NOP_INSTR);
  assign bus.inst_pc    = !fifo_empty ? head.pc : rpc;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      fpc         <= RESET_PC;
      rpc         <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (bus.redirect) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fpc         <= word_align(bus.redirect_pc);
      rpc         <= word_align(bus.redirect_pc);
      outstanding <= outstanding - CW'(rsp_valid);
      drop        <= outstanding - CW'(rsp_valid);
    end else begin
      if (grant) fpc <= fpc + 32'd4;
      if (keep)  rpc <= rpc + 32'd4;
      if (rsp_valid && (drop != '0)) drop <= drop - 1'b1;
      outstanding <= outstanding + CW'(grant) - CW'(rsp_valid);
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .res       (res),
    .flush     (bus.redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - randomized and directed self-checking bench for instr_prefetch
module tb_instr_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  instr_prefetch_if bus();

  instr_prefetch #(.DEPTH(4), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  bit          lat_rand = 0;
  bit          spur     = 0;
  int          n_pops   = 0;
  int          n_grants = 0;
  int          first_valid = -1;
  logic [31:0] exp_pc;
  logic [31:0] first_pop_pc;
  logic        s_req, s_valid, s_rvalid;
  logic [31:0] s_addr, s_data, s_pc;
  bit          have_prev = 0;
  logic        prev_req, prev_gnt;
  logic [31:0] prev_addr;
  bit          seen_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_restart();
    pend.delete();
    exp_pc      = RESET_PC;
    cyc         = 0;
    have_prev   = 0;
    n_pops      = 0;
    n_grants    = 0;
    first_valid = -1;
  endtask

  task automatic do_reset();
    res             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 1'b0;
    spur            = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    model_restart();
  endtask

  // One clock: drive inputs after negedge, sample, update the reference model, advance.
  task automatic cycle(input logic g, input logic r, input logic rd, input logic [31:0] tgt);
    bit real_rsp;
    bus.imem_gnt    = g;
    bus.inst_ready  = r;
    bus.redirect    = rd;
    bus.redirect_pc = tgt;
    real_rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    if (real_rsp) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend[0].addr);
    end else if (spur) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
    #1;
    s_req    = bus.imem_req;
    s_addr   = bus.imem_addr;
    s_valid  = bus.inst_valid;
    s_data   = bus.inst_data;
    s_pc     = bus.inst_pc;
    s_rvalid = bus.imem_rvalid;
    if (have_prev && prev_req && !prev_gnt && !rd) begin
      check("req_hold", {31'b0, s_req}, 32'd1);
      check("addr_hold", s_addr, prev_addr);
    end
    if (s_valid && first_valid < 0) first_valid = cyc;
    if (s_valid && r && !rd) begin
      if (n_pops == 0) first_pop_pc = s_pc;
      check("pop_pc", s_pc, exp_pc);
      check("pop_data", s_data, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_pops++;
    end
    if (real_rsp) void'(pend.pop_front());
    if (s_req && g) begin
      if (lat_rand) lat = $urandom_range(1, 3);
      pend.push_back('{addr: s_addr, due: cyc + lat});
      n_grants++;
      check("inflight_bound", {31'b0, pend.size() <= 4}, 32'd1);
    end
    if (rd) exp_pc = {tgt[31:2], 2'b00};
    have_prev = 1;
    prev_req  = s_req;
    prev_gnt  = g;
    prev_addr = s_addr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 1'b0;
    exp_pc          = RESET_PC;
    first_pop_pc    = '1;
    #3;
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, RESET_PC);
    check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rst_data", bus.inst_data, NOP);
    check("rst_pc", bus.inst_pc, RESET_PC);

    // Full-rate streaming with single-cycle memory.
    do_reset();
    lat = 1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (i < 8) check("addr_seq", s_addr, 32'(i * 4));
    end
`ifdef PREFETCH_BYPASS_EN
    check("first_valid", first_valid, 1);
    check("stream_pops", n_pops, 11);
`else
    check("first_valid", first_valid, 2);
    check("stream_pops", n_pops, 10);
`endif

    // Core stalled: exactly DEPTH grants, then drain in order.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    check("full_grants", n_grants, 4);
    check("full_req_low", {31'b0, s_req}, 32'd0);
    check("full_valid", {31'b0, s_valid}, 32'd1);
    seen_req = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (s_req) seen_req = 1;
    end
    check("drain_req_back", {31'b0, seen_req}, 32'd1);
    check("drain_min_pops", {31'b0, n_pops >= 4}, 32'd1);

    // Redirect with two slow responses in flight.
    do_reset();
    lat = 3;
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0042);
    check("redir_req_low", {31'b0, s_req}, 32'd0);
    n_pops = 0;
    cycle(1'b1, 1'b1, 1'b0, '0);
    check("redir_addr", s_addr, 32'h0000_0040);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check("redir_first_pc", first_pop_pc, 32'h0000_0040);

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check("coinc_rvalid", {31'b0, s_rvalid}, 32'd1);
    check("coinc_valid", {31'b0, s_valid}, 32'd1);
    n_pops = 0;
    cycle(1'b1, 1'b1, 1'b0, '0);
    check("coinc_flushed", {31'b0, s_valid}, 32'd0);
    check("coinc_nop", s_data, NOP);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check("coinc_first_pc", first_pop_pc, 32'h0000_0200);

    // Fetch address wraps modulo 2^32; low target bits ignored.
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9);
    n_pops = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check("wrap_first_pc", first_pop_pc, 32'hFFFF_FFF8);
    check("wrap_pops", {31'b0, n_pops >= 4}, 32'd1);

    // Spurious response with nothing outstanding is ignored.
    do_reset();
    spur = 1;
    cycle(1'b0, 1'b0, 1'b0, '0);
    spur = 0;
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("spur_valid", {31'b0, s_valid}, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check("spur_first_pc", first_pop_pc, RESET_PC);

    // Grant withheld: request and address hold steady.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    begin
      logic [31:0] a0;
      a0 = '0;
      for (int i = 0; i < 5; i++) begin
        cycle(1'b0, 1'b1, 1'b0, '0);
        if (i == 0) a0 = s_addr;
        check("stall_req", {31'b0, s_req}, 32'd1);
        check("stall_addr", s_addr, a0);
      end
      cycle(1'b1, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b0, '0);
      check("stall_advance", s_addr, a0 + 32'd4);
    end

    // Asynchronous reset with two words queued and one outstanding.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    lat = 3;
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("pre_rst_valid", {31'b0, s_valid}, 32'd1);
    bus.imem_rvalid = 1'b0;
    res = 1'b1;
    #1;
    check("arst_req", {31'b0, bus.imem_req}, 32'd0);
    check("arst_addr", bus.imem_addr, RESET_PC);
    check("arst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("arst_data", bus.inst_data, NOP);
    check("arst_pc", bus.inst_pc, RESET_PC);
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    model_restart();
    lat = 1;
    cycle(1'b1, 1'b1, 1'b0, '0);
    check("restart_addr", s_addr, RESET_PC);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check("restart_pops", {31'b0, n_pops >= 3}, 32'd1);

    // Randomized traffic with variable latency and occasional redirects.
    do_reset();
    lat_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      logic        g, r, rd;
      logic [31:0] tgt;
      g   = ($urandom % 10) < 7;
      r   = ($urandom % 10) < 6;
      rd  = ($urandom % 24) == 0;
      tgt = $urandom;
      cycle(g, r, rd, tgt);
    end
    check("rand_progress", {31'b0, n_pops > 100}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
